// File: rtl/forney_err_collect_pkg.sv
//------------------------------------------------------------------------------
// forney_pkg : widths, FIFO entry layout and collector states shared by the
// Forney error collector. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package forney_pkg;

   localparam int SYM_W = 10;
   localparam int POS_W = 10;
   localparam int T_MAX = 15;
   localparam int CNT_W = 5;

   typedef struct packed {
      logic [POS_W-1:0] pos;
      logic [SYM_W-1:0] val;
      logic             last;
   } err_entry_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } collect_state_e;

endpackage

`default_nettype wire

// File: rtl/forney_err_collect_fifo.sv
//------------------------------------------------------------------------------
// err_fifo_fwft : first-word-fall-through FIFO; the head entry is visible on
// o_rdata whenever o_valid is high. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module err_fifo_fwft #(
   parameter int WIDTH = 21,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic                       o_valid,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;

   logic w_full;
   logic w_empty;
   logic w_do_push;
   logic w_do_pop;

   assign w_full    = (r_count == (AW+1)'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !w_empty;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
   assign w_do_push = i_push && (!w_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_valid = !w_empty;
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/forney_err_collect.sv
//------------------------------------------------------------------------------
// forney_err_collect : pulls Forney results lane by lane through an external
// round-robin arbiter, streams them out and checks the per-codeword count.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module forney_err_collect
   import forney_pkg::*;
#(
   parameter int LANES      = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     srst,
   input  logic                     cw_start,
   input  logic [CNT_W-1:0]         num_err_exp,
   input  logic                     chien_done,
   input  logic [LANES-1:0]         lane_valid,
   input  logic [LANES*POS_W-1:0]   lane_pos,
   input  logic [LANES*SYM_W-1:0]   lane_val,
   output logic [LANES-1:0]         lane_ack,
   output logic [LANES-1:0]         arb_req,
   output logic                     arb_en,
   input  logic [LANES-1:0]         arb_grant,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [POS_W-1:0]         out_pos,
   output logic [SYM_W-1:0]         out_val,
   output logic                     out_last,
   output logic                     cw_done,
   output logic [CNT_W-1:0]         cw_err_cnt,
   output logic                     cw_fail
);

   localparam int FIFO_AW = $clog2(FIFO_DEPTH);

   collect_state_e   r_state;
   logic [CNT_W-1:0] r_exp;
   logic [CNT_W-1:0] r_cnt;
   logic             r_fail;
   logic             r_chien_seen;
   logic             r_cw_done;

   logic             w_any_valid;
   logic             w_any_grant;
   logic             w_chien_seen;
   logic             w_write;
   logic             w_discard;
   logic             w_last;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [POS_W-1:0] w_sel_pos;
   logic [SYM_W-1:0] w_sel_val;
   err_entry_t       w_entry;
   err_entry_t       w_head;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic             w_fifo_valid;
   logic [FIFO_AW:0] w_fifo_count;

   assign w_any_valid  = |lane_valid;
   assign w_any_grant  = |arb_grant;
   assign w_chien_seen = r_chien_seen | chien_done;
   assign w_cnt_inc    = r_cnt + 1'b1;
   assign w_last       = (w_cnt_inc == r_exp);

   always_comb begin
      arb_req   = '0;
      arb_en    = 1'b0;
      lane_ack  = '0;
      w_write   = 1'b0;
      w_discard = 1'b0;
      case (r_state)
         COLLECT: begin
            arb_req = lane_valid;
            arb_en  = !w_fifo_full;
            if (!w_fifo_full && w_any_grant) begin
               lane_ack = arb_grant;
               w_write  = 1'b1;
            end
         end
         DRAIN: begin
            arb_req = lane_valid;
            arb_en  = w_any_valid;
            // Results beyond the expected count are popped and dropped.
            if (w_any_valid && w_any_grant) begin
               lane_ack  = arb_grant;
               w_discard = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      w_sel_pos = '0;
      w_sel_val = '0;
      for (int i = 0; i < LANES; i++) begin
         w_sel_pos = w_sel_pos | (lane_pos[i*POS_W +: POS_W] & {POS_W{arb_grant[i]}});
         w_sel_val = w_sel_val | (lane_val[i*SYM_W +: SYM_W] & {SYM_W{arb_grant[i]}});
      end
   end

   assign w_entry = '{pos: w_sel_pos, val: w_sel_val, last: w_last};

   always_ff @(posedge clk_i) begin
      if (srst) begin
         r_state      <= IDLE;
         r_exp        <= '0;
         r_cnt        <= '0;
         r_fail       <= 1'b0;
         r_chien_seen <= 1'b0;
         r_cw_done    <= 1'b0;
      end else begin
         r_cw_done <= 1'b0;
         if (r_state != IDLE && chien_done) begin
            r_chien_seen <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (cw_start) begin
                  r_exp        <= num_err_exp;
                  r_cnt        <= '0;
                  r_fail       <= 1'b0;
                  r_chien_seen <= 1'b0;
                  r_state      <= (num_err_exp == '0) ? DRAIN : COLLECT;
               end
            end
            COLLECT: begin
               if (w_write) begin
                  r_cnt <= w_cnt_inc;
                  if (w_last) begin
                     r_state <= DRAIN;
                  end
               end else if (w_chien_seen && !w_any_valid) begin
                  // Chien search is over and fewer results than expected arrived.
                  r_fail  <= 1'b1;
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_discard) begin
                  r_fail <= 1'b1;
               end
               if (w_fifo_empty && !w_any_valid && w_chien_seen) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_cw_done <= 1'b1;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   err_fifo_fwft #(
      .WIDTH ($bits(err_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk_i),
      .rst     (srst),
      .i_push  (w_write),
      .i_wdata (w_entry),
      .i_pop   (out_ready),
      .o_rdata (w_head),
      .o_valid (w_fifo_valid),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   assign out_valid  = w_fifo_valid;
   assign out_pos    = w_head.pos;
   assign out_val    = w_head.val;
   assign out_last   = w_head.last;
   assign cw_done    = r_cw_done;
   assign cw_err_cnt = r_cnt;
   assign cw_fail    = r_fail;

   a_grant_onehot: assert property (@(posedge clk_i) disable iff (srst)
      arb_en |-> $onehot0(arb_grant));

   a_fifo_bound: assert property (@(posedge clk_i) disable iff (srst)
      w_fifo_count <= (FIFO_AW+1)'(FIFO_DEPTH));

endmodule

`default_nettype wire

// File: tb/tb_forney_err_collect.sv
//------------------------------------------------------------------------------
// tb_forney_err_collect : randomized codewords against a round-robin ordering
// model, plus directed boundary cases. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_forney_err_collect;
   import forney_pkg::*;

   localparam int LANES = 32;
   localparam int DEPTH = 4;

   logic                   clk_i = 1'b0;
   logic                   srst = 1'b1;
   logic                   cw_start = 1'b0;
   logic [CNT_W-1:0]       num_err_exp = '0;
   logic                   chien_done = 1'b0;
   logic [LANES-1:0]       lane_valid = '0;
   logic [LANES*POS_W-1:0] lane_pos;
   logic [LANES*SYM_W-1:0] lane_val;
   logic [LANES-1:0]       lane_ack;
   logic [LANES-1:0]       arb_req;
   logic                   arb_en;
   logic [LANES-1:0]       arb_grant;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [POS_W-1:0]       out_pos;
   logic [SYM_W-1:0]       out_val;
   logic                   out_last;
   logic                   cw_done;
   logic [CNT_W-1:0]       cw_err_cnt;
   logic                   cw_fail;

   always #5 clk_i = ~clk_i;

   forney_err_collect #(.LANES(LANES), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .srst(srst), .cw_start(cw_start), .num_err_exp(num_err_exp),
      .chien_done(chien_done), .lane_valid(lane_valid), .lane_pos(lane_pos),
      .lane_val(lane_val), .lane_ack(lane_ack), .arb_req(arb_req), .arb_en(arb_en),
      .arb_grant(arb_grant), .out_valid(out_valid), .out_ready(out_ready),
      .out_pos(out_pos), .out_val(out_val), .out_last(out_last), .cw_done(cw_done),
      .cw_err_cnt(cw_err_cnt), .cw_fail(cw_fail)
   );

   logic [POS_W-1:0] lp [LANES];
   logic [SYM_W-1:0] lv [LANES];

   always_comb begin
      lane_pos = '0;
      lane_val = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_pos[i*POS_W +: POS_W] = lp[i];
         lane_val[i*SYM_W +: SYM_W] = lv[i];
      end
   end

   // Round-robin arbiter: first requester at or after the pointer wins.
   int arb_ptr;
   always_comb begin
      logic found;
      found     = 1'b0;
      arb_grant = '0;
      if (arb_en) begin
         for (int j = 0; j < LANES; j++) begin
            int l;
            l = (arb_ptr + j) % LANES;
            if (!found && arb_req[l]) begin
               arb_grant[l] = 1'b1;
               found        = 1'b1;
            end
         end
      end
   end

   always @(posedge clk_i) begin
      if (srst) arb_ptr <= 0;
      else if (arb_en) begin
         for (int j = 0; j < LANES; j++)
            if (arb_grant[j]) arb_ptr <= (j + 1) % LANES;
      end
   end

   int               checks = 0;
   int               failures = 0;
   err_entry_t       sb [$];
   int               m_ptr = 0;
   logic [LANES-1:0] ack_q = '0;
   int               acks;
   bit               done_seen;
   bit               prev_stall = 1'b0;
   err_entry_t       prev;
   bit               hold_rdy = 1'b0;
   bit               rnd_rdy = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic sample();
      err_entry_t e;
      chk("ack_subset", 32'(lane_ack & ~lane_valid), 32'd0);
      if (out_valid && prev_stall) begin
         chk("stall_pos", 32'(out_pos), 32'(prev.pos));
         chk("stall_val", 32'(out_val), 32'(prev.val));
         chk("stall_last", 32'(out_last), 32'(prev.last));
      end
      if (out_valid && out_ready) begin
         chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_pos", 32'(out_pos), 32'(e.pos));
            chk("out_val", 32'(out_val), 32'(e.val));
            chk("out_last", 32'(out_last), 32'(e.last));
         end
      end
      prev_stall = out_valid && !out_ready;
      prev       = '{pos: out_pos, val: out_val, last: out_last};
      ack_q      = lane_ack;
      acks      += $countones(lane_ack);
      if (cw_done) done_seen = 1'b1;
   endtask

   task automatic step(input logic chien);
      @(posedge clk_i); #1;
      lane_valid = lane_valid & ~ack_q;
      ack_q      = '0;
      cw_start   = 1'b0;
      chien_done = chien;
      if (hold_rdy)     out_ready = 1'b0;
      else if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      else              out_ready = 1'b1;
      @(negedge clk_i);
      sample();
   endtask

   task automatic run_cw(input int e, input logic [LANES-1:0] m, input int hold,
                         input bit rnd, output int first_vld, output int done_lat);
      int n, k, last_l, d, exp_cnt;
      bit exp_fail;
      n = $countones(m);
      k = 0;
      last_l = 0;
      // Lanes are served in circular order from the arbiter pointer; the first
      // e results are kept and the e-th carries last.
      for (int j = 0; j < LANES; j++) begin
         int l;
         l = (m_ptr + j) % LANES;
         if (m[l]) begin
            lp[l] = POS_W'($urandom_range(0, 543));
            lv[l] = SYM_W'($urandom);
            if (k < e) sb.push_back('{pos: lp[l], val: lv[l], last: (k == e - 1)});
            k++;
            last_l = l;
         end
      end
      if (n > 0) m_ptr = (last_l + 1) % LANES;
      exp_cnt  = (n < e) ? n : e;
      exp_fail = (n != e);
      acks = 0; done_seen = 1'b0; first_vld = -1; done_lat = -1;
      d = $urandom_range(1, 30);
      hold_rdy = (hold > 0);
      rnd_rdy  = rnd;
      @(posedge clk_i); #1;
      lane_valid  = m;
      cw_start    = 1'b1;
      num_err_exp = CNT_W'(e);
      chien_done  = 1'b0;
      out_ready   = !hold_rdy;
      @(negedge clk_i);
      sample();
      for (int cyc = 1; cyc <= 3000 && !done_seen; cyc++) begin
         hold_rdy = (cyc <= hold);
         step(cyc == d);
         if (first_vld < 0 && out_valid) first_vld = cyc;
         if (cyc == hold && n >= DEPTH && e >= DEPTH) begin
            chk("full_arb_en", 32'(arb_en), 32'd0);
            chk("full_lane_ack", 32'(lane_ack), 32'd0);
            chk("full_accepted", 32'(acks), 32'(DEPTH));
         end
         if (done_seen) done_lat = cyc - d;
      end
      chk("cw_done_seen", 32'(done_seen), 32'd1);
      chk("cw_err_cnt", 32'(cw_err_cnt), 32'(exp_cnt));
      chk("cw_fail", 32'(cw_fail), 32'(exp_fail));
      chk("sb_drained", 32'(sb.size()), 32'd0);
      sb.delete();
      hold_rdy = 1'b0;
      step(1'b0);
      chk("cw_done_pulse", 32'(cw_done), 32'd0);
   endtask

   function automatic logic [LANES-1:0] rand_mask(input int n);
      logic [LANES-1:0] m;
      m = '0;
      while ($countones(m) < n) m[$urandom_range(0, LANES - 1)] = 1'b1;
      return m;
   endfunction

   initial begin
      int fv, dl;
      logic [LANES-1:0] m;
      for (int i = 0; i < LANES; i++) begin
         lp[i] = '0;
         lv[i] = '0;
      end
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_lane_ack", 32'(lane_ack), 32'd0);
      chk("rst_arb_en", 32'(arb_en), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_cw_done", 32'(cw_done), 32'd0);
      chk("rst_cw_fail", 32'(cw_fail), 32'd0);
      chk("rst_cw_err_cnt", 32'(cw_err_cnt), 32'd0);
      @(posedge clk_i); #1;
      srst = 1'b0;

      m = '0; m[5] = 1'b1; m[17] = 1'b1; m[30] = 1'b1;
      run_cw(3, m, 0, 1'b0, fv, dl);
      chk("fwft_latency", 32'(fv), 32'd2);

      run_cw(15, rand_mask(15), 30, 1'b0, fv, dl);
      run_cw(10, rand_mask(10), 20, 1'b0, fv, dl);
      run_cw(4, rand_mask(2), 0, 1'b1, fv, dl);
      run_cw(2, rand_mask(3), 0, 1'b1, fv, dl);
      run_cw(0, '0, 0, 1'b0, fv, dl);
      chk("zero_done_latency", 32'(dl), 32'd2);

      // Abort mid-codeword with the FIFO partly filled.
      m = rand_mask(8);
      @(posedge clk_i); #1;
      lane_valid = m; cw_start = 1'b1; num_err_exp = CNT_W'(5); out_ready = 1'b0;
      hold_rdy = 1'b1;
      @(negedge clk_i);
      sample();
      step(1'b0);
      step(1'b0);
      @(posedge clk_i); #1;
      srst = 1'b1;
      @(posedge clk_i); #1;
      srst = 1'b0;
      @(negedge clk_i);
      chk("abort_lane_ack", 32'(lane_ack), 32'd0);
      chk("abort_arb_req", 32'(arb_req), 32'd0);
      chk("abort_arb_en", 32'(arb_en), 32'd0);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_cw_done", 32'(cw_done), 32'd0);
      chk("abort_cw_fail", 32'(cw_fail), 32'd0);
      chk("abort_cw_err_cnt", 32'(cw_err_cnt), 32'd0);
      lane_valid = '0; ack_q = '0; sb.delete(); m_ptr = 0; hold_rdy = 1'b0;
      done_seen = 1'b0;
      step(1'b1);
      repeat (20) step(1'b0);
      chk("abort_no_done", 32'(done_seen), 32'd0);

      for (int it = 0; it < 40; it++) begin
         run_cw($urandom_range(0, 15), rand_mask($urandom_range(0, 20)),
                ($urandom_range(0, 2) == 0) ? $urandom_range(5, 25) : 0, 1'b1, fv, dl);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
